// File: rtl/button_pkg.sv
// Shared types and default timing for the button debouncer / event decoder pair.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } btn_evt_state_t;

  localparam int unsigned BTN_LONG_TICKS   = 100_000_000;
  localparam int unsigned BTN_DOUBLE_TICKS = 30_000_000;

  // Counter width able to reach the larger of the two terminal counts.
  function automatic int unsigned btn_cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/button_event_timer.sv
// Clearable up-counter with a runtime terminal-count compare.
module button_event_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign hit = (cnt == limit);

endmodule

// File: rtl/button_event_decoder.sv
// Classifies the debounced button level into press/release/click/double/long pulses.
//
//   state  | meaning
//   IDLE   | button up, no gesture in progress
//   PRESS1 | first press running, timing toward long press
//   WAIT2  | first press released, waiting for a second press
//   PRESS2 | second press running, timing toward long press
//   LONG   | long press reported, waiting for release
module button_event_decoder
  import button_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = BTN_LONG_TICKS,
  parameter int unsigned DOUBLE_TICKS = BTN_DOUBLE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic debounced,
  output logic press,
  output logic release_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic held
);

  localparam int unsigned CW = btn_cnt_width(LONG_TICKS, DOUBLE_TICKS);
  localparam logic [CW-1:0] LONG_LIMIT   = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] DOUBLE_LIMIT = CW'(DOUBLE_TICKS - 1);

  btn_evt_state_t state_q, state_d;
  logic [CW-1:0]  limit;
  logic           cnt_en;
  logic           cnt_clear;
  logic           hit;

  logic press_d, release_d, single_d, double_d, long_d, held_d;

  button_event_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .limit (limit),
    .hit   (hit)
  );

  // Input level is tested before the terminal count everywhere, so a
  // coincident edge always wins over a timeout.
  always_comb begin
    state_d   = state_q;
    limit     = LONG_LIMIT;
    cnt_en    = 1'b0;
    press_d   = 1'b0;
    release_d = 1'b0;
    single_d  = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (debounced) begin
          state_d = PRESS1;
          press_d = 1'b1;
        end
      end
      PRESS1: begin
        cnt_en = 1'b1;
        if (!debounced) begin
          state_d   = WAIT2;
          release_d = 1'b1;
        end else if (hit) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        limit  = DOUBLE_LIMIT;
        cnt_en = 1'b1;
        if (debounced) begin
          state_d = PRESS2;
          press_d = 1'b1;
        end else if (hit) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end
      end
      PRESS2: begin
        cnt_en = 1'b1;
        if (!debounced) begin
          state_d   = IDLE;
          release_d = 1'b1;
          double_d  = 1'b1;
        end else if (hit) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      LONG: begin
        if (!debounced) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_clear = (state_d != state_q);
    held_d    = (state_d == PRESS1) || (state_d == PRESS2) || (state_d == LONG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      single_click  <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_d;
      press         <= press_d;
      release_pulse <= release_d;
      single_click  <= single_d;
      double_click  <= double_d;
      long_press    <= long_d;
      held          <= held_d;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with LONG_TICKS=8, DOUBLE_TICKS=5.
module tb_button_event_decoder;
  import button_pkg::*;

  // Output vector bit order: {press, release, single, double, long, held}
  localparam logic [5:0] P = 6'b100000;
  localparam logic [5:0] R = 6'b010000;
  localparam logic [5:0] S = 6'b001000;
  localparam logic [5:0] D = 6'b000100;
  localparam logic [5:0] L = 6'b000010;
  localparam logic [5:0] H = 6'b000001;
  localparam logic [5:0] Z = 6'b000000;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } sb_item_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic debounced = 1'b0;
  logic press, release_pulse, single_click, double_click, long_press, held;

  sb_item_t sb_q[$];
  string    cur_name = "init";
  int       vectors = 0;
  int       errors = 0;

  button_event_decoder #(.LONG_TICKS(8), .DOUBLE_TICKS(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .debounced     (debounced),
    .press         (press),
    .release_pulse (release_pulse),
    .single_click  (single_click),
    .double_click  (double_click),
    .long_press    (long_press),
    .held          (held)
  );

  always #5 clk = ~clk;

  // Monitor: one expected vector per sampled edge, compared just after it.
  initial begin
    sb_item_t it;
    logic [5:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        got = {press, release_pulse, single_click, double_click, long_press, held};
        vectors++;
        if (got !== it.exp) begin
          errors++;
          $display("FAIL %s t=%0t: got %b required %b (press,rel,single,double,long,held)",
                   it.name, $time, got, it.exp);
        end
      end
    end
  end

  task automatic run(input logic r, input logic d, input logic [5:0] e, input int n);
    sb_item_t it;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset     = r;
      debounced = d;
      it.exp    = e;
      it.name   = cur_name;
      sb_q.push_back(it);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cur_name = "reset_hold";
    run(1, 1, Z, 1);
    run(1, 0, Z, 1);
    run(1, 1, Z, 1);

    cur_name = "reset_release_press";
    run(0, 1, P | H, 1);
    run(0, 0, R, 1);
    run(0, 0, Z, 4);
    run(0, 0, S, 1);
    run(0, 0, Z, 2);

    cur_name = "single_click";
    run(0, 1, P | H, 1);
    run(0, 1, H, 2);
    run(0, 0, R, 1);
    run(0, 0, Z, 4);
    run(0, 0, S, 1);
    run(0, 0, Z, 2);

    cur_name = "double_click";
    run(0, 1, P | H, 1);
    run(0, 1, H, 1);
    run(0, 0, R, 1);
    run(0, 0, Z, 3);
    run(0, 1, P | H, 1);
    run(0, 1, H, 1);
    run(0, 0, R | D, 1);
    run(0, 0, Z, 6);

    cur_name = "long_press";
    run(0, 1, P | H, 1);
    run(0, 1, H, 7);
    run(0, 1, L | H, 1);
    run(0, 1, H, 11);
    run(0, 0, R, 1);
    run(0, 0, Z, 6);

    cur_name = "bound_release_at_terminal";
    run(0, 1, P | H, 1);
    run(0, 1, H, 7);
    run(0, 0, R, 1);
    run(0, 0, Z, 4);
    run(0, 0, S, 1);
    run(0, 0, Z, 1);

    cur_name = "bound_hold_one_more";
    run(0, 1, P | H, 1);
    run(0, 1, H, 7);
    run(0, 1, L | H, 1);
    run(0, 0, R, 1);
    run(0, 0, Z, 6);

    cur_name = "bound_second_press_at_terminal";
    run(0, 1, P | H, 1);
    run(0, 0, R, 1);
    run(0, 0, Z, 4);
    run(0, 1, P | H, 1);
    run(0, 0, R | D, 1);
    run(0, 0, Z, 6);

    cur_name = "bound_second_press_late";
    run(0, 1, P | H, 1);
    run(0, 0, R, 1);
    run(0, 0, Z, 4);
    run(0, 0, S, 1);
    run(0, 1, P | H, 1);
    run(0, 0, R, 1);
    run(0, 0, Z, 4);
    run(0, 0, S, 1);
    run(0, 0, Z, 1);

    cur_name = "reset_mid_wait2";
    run(0, 1, P | H, 1);
    run(0, 0, R, 1);
    run(0, 0, Z, 2);
    run(1, 0, Z, 2);
    @(negedge clk);
    vectors++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_state: got %0d required %0d", dut.state_q, IDLE);
    end
    vectors++;
    if (dut.u_timer.cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_cnt: got %0d required 0", dut.u_timer.cnt);
    end
    run(0, 0, Z, 8);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
